signed_multiplier_unit: RTL and testbench

Sequential two's-complement multiplier. It uses radix-2 Booth recoding and computes an N x N signed product into a 2N-bit signed result over N iterations. A start/busy/done handshake frames each operation. It is a reusable arithmetic unit for datapaths that can tolerate multi-cycle latency in exchange for small area.

---
 rtl/signed_multiplier_unit_if.sv | 27 ++
 rtl/signed_multiplier_unit.sv | 130 +++++++++++++
 tb/tb_signed_multiplier_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/signed_multiplier_unit_if.sv
// rtl/signed_multiplier_unit_if.sv - start/busy/done handshake and operand/result bus of the signed multiplier
// Ports (interface members):
//   start   : request a multiply (driven by the master)
//   A, B    : N-bit two's-complement multiplicand and multiplier
//   product : 2N-bit two's-complement result register
//   busy    : operation in progress
//   done    : one-cycle pulse, product newly valid
interface signed_multiplier_unit_if #(
    parameter int N = 8
);
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [2*N-1:0] product;
    logic           busy;
    logic           done;

    modport master (
        output start, A, B,
        input  product, busy, done
    );

    modport slave (
        input  start, A, B,
        output product, busy, done
    );
endinterface

// File: rtl/signed_multiplier_unit.sv
// rtl/signed_multiplier_unit.sv - sequential radix-2 Booth N x N signed multiplier
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of signed_multiplier_unit_if (start, A, B in; product, busy, done out)
// Timing: start accepted on edge 0, N Booth iterations on edges 1..N, product and
// done update on edge N+1. A start seen in DONE is accepted directly, giving one
// result every N+2 cycles when start is held.
module signed_multiplier_unit #(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    signed_multiplier_unit_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // Upper half is N+1 bits so that subtracting/adding -2^(N-1) cannot overflow.
    logic signed [N:0]   r_hi;
    logic signed [N:0]   r_mcand;
    logic [N-1:0]        r_lo;
    logic                r_q;
    logic [CW-1:0]       r_cnt;
    logic [2*N-1:0]      r_product;

    logic                w_load;
    logic                w_step;
    logic                w_finish;
    logic                w_busy;
    logic                w_done;
    logic signed [N:0]   w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_cnt != '0) begin
                    w_step = 1'b1;
                end else begin
                    // All N iterations are in; publish the result on this edge.
                    w_finish = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                // Accepting here (rather than one cycle later in IDLE) is what
                // gives the N+2 cycle back-to-back throughput.
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Booth recoding of the pair {acc[0], q(-1)}.
    always_comb begin
        case ({r_lo[0], r_q})
            2'b01:   w_sum = r_hi + r_mcand;
            2'b10:   w_sum = r_hi - r_mcand;
            default: w_sum = r_hi;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi      <= '0;
            r_mcand   <= '0;
            r_lo      <= '0;
            r_q       <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            if (w_load) begin
                r_mcand <= {bus.A[N-1], bus.A};
                r_hi    <= '0;
                r_lo    <= bus.B;
                r_q     <= 1'b0;
                r_cnt   <= CW'(N);
            end else if (w_step) begin
                // Arithmetic right shift of {hi, lo, q} after the add/subtract.
                r_hi  <= {w_sum[N], w_sum[N:1]};
                r_lo  <= {w_sum[0], r_lo[N-1:1]};
                r_q   <= r_lo[0];
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_finish) begin
                r_product <= {r_hi[N-1:0], r_lo};
            end
        end
    end

    assign bus.product = r_product;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
endmodule

// File: tb/tb_signed_multiplier_unit.sv
// tb/tb_signed_multiplier_unit.sv - self-checking bench for signed_multiplier_unit at N=4, 8 and 16
module tb_signed_multiplier_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    signed_multiplier_unit_if #(.N(4))  if4 ();
    signed_multiplier_unit_if #(.N(8))  if8 ();
    signed_multiplier_unit_if #(.N(16)) if16 ();

    signed_multiplier_unit #(.N(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
    signed_multiplier_unit #(.N(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
    signed_multiplier_unit #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input bit s, input longint a, input longint b);
        case (w)
            4:       begin if4.start  = s; if4.A  = a[3:0];  if4.B  = b[3:0];  end
            8:       begin if8.start  = s; if8.A  = a[7:0];  if8.B  = b[7:0];  end
            default: begin if16.start = s; if16.A = a[15:0]; if16.B = b[15:0]; end
        endcase
    endtask

    function automatic bit busy_of(input int w);
        case (w)
            4:       return if4.busy;
            8:       return if8.busy;
            default: return if16.busy;
        endcase
    endfunction

    function automatic bit done_of(input int w);
        case (w)
            4:       return if4.done;
            8:       return if8.done;
            default: return if16.done;
        endcase
    endfunction

    function automatic logic signed [63:0] prod_of(input int w);
        case (w)
            4:       return 64'($signed(if4.product));
            8:       return 64'($signed(if8.product));
            default: return 64'($signed(if16.product));
        endcase
    endfunction

    // One complete operation: latency from accepting edge to done, product, busy profile.
    task automatic do_mul(input int w, input longint a, input longint b, input string tag);
        int               lat;
        bit               all_busy;
        logic signed [63:0] prod;
        @(negedge clk);
        drive(w, 1'b1, a, b);
        @(posedge clk);
        #1;
        drive(w, 1'b0, a, b);
        lat      = -1;
        all_busy = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (!busy_of(w)) all_busy = 1'b0;
            if (done_of(w)) begin
                lat = k;
                break;
            end
        end
        prod = prod_of(w);
        check_eq({tag, "_latency"}, lat, w + 1);
        check_eq({tag, "_product"}, prod, a * b);
        check_eq({tag, "_busy_during"}, all_busy, 1);
        @(posedge clk);
        #1;
        check_eq({tag, "_idle_after"}, busy_of(w), 0);
        check_eq({tag, "_done_pulse"}, done_of(w), 0);
        check_eq({tag, "_product_held"}, prod_of(w), a * b);
    endtask

    initial begin
        int     n_done;
        int     last_done;
        int     waited;
        longint ra;
        longint rb;
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        drive(4, 1'b0, 0, 0);
        drive(8, 1'b0, 0, 0);
        drive(16, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_product", prod_of(8), 0);
        check_eq("reset_busy", busy_of(8), 0);
        check_eq("reset_done", done_of(8), 0);

        do_mul(8, 7, 81, "basic");
        do_mul(8, -7, 81, "neg_a");
        do_mul(8, 7, -81, "neg_b");
        do_mul(8, -7, -81, "neg_ab");
        do_mul(8, -128, -128, "min_min");
        do_mul(8, -128, 127, "min_max");
        do_mul(8, 127, 127, "max_max");
        do_mul(8, 0, -5, "zero");
        do_mul(8, -1, -1, "m1_m1");
        do_mul(4, -8, -8, "n4_min_min");
        do_mul(16, -32768, -32768, "n16_min_min");

        // start re-asserted and operands changed mid-CALC
        @(negedge clk);
        drive(8, 1'b1, 13, -9);
        n_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) drive(8, 1'b0, 13, -9);
            if (c == 2) drive(8, 1'b1, -100, 77);
            if (c == 4) drive(8, 1'b0, 55, 3);
            if (done_of(8)) begin
                n_done++;
                check_eq("midcalc_done_edge", c, 9);
                check_eq("midcalc_product", prod_of(8), -117);
            end
        end
        check_eq("midcalc_done_count", n_done, 1);

        // start held continuously: back-to-back operations
        @(negedge clk);
        drive(8, 1'b1, 5, 6);
        n_done    = 0;
        last_done = -1;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk);
            #1;
            if (done_of(8)) begin
                if (last_done >= 0) check_eq("hold_done_spacing", c - last_done, 10);
                else check_eq("hold_first_done", c, 9);
                check_eq("hold_product", prod_of(8), 30);
                last_done = c;
                n_done++;
            end
        end
        drive(8, 1'b0, 5, 6);
        check_eq("hold_done_count", n_done, 3);
        waited = 0;
        while (busy_of(8) && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check_eq("hold_drain", busy_of(8), 0);

        // asynchronous reset between edges during CALC
        @(negedge clk);
        drive(8, 1'b1, -50, 3);
        @(posedge clk);
        #1;
        drive(8, 1'b0, -50, 3);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_product", prod_of(8), 0);
        check_eq("arst_busy", busy_of(8), 0);
        check_eq("arst_done", done_of(8), 0);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (done_of(8) || busy_of(8)) n_done++;
        end
        check_eq("arst_no_done", n_done, 0);
        do_mul(8, -50, 3, "after_reset");

        // randomized against plain signed multiplication
        for (int i = 0; i < 1000; i++) begin
            ra = longint'($urandom_range(0, 255)) - 128;
            rb = longint'($urandom_range(0, 255)) - 128;
            do_mul(8, ra, rb, "rand8");
        end
        for (int i = 0; i < 150; i++) begin
            ra = longint'($urandom_range(0, 15)) - 8;
            rb = longint'($urandom_range(0, 15)) - 8;
            do_mul(4, ra, rb, "rand4");
        end
        for (int i = 0; i < 150; i++) begin
            ra = longint'($urandom_range(0, 65535)) - 32768;
            rb = longint'($urandom_range(0, 65535)) - 32768;
            do_mul(16, ra, rb, "rand16");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
